nibble_deserializer: RTL and testbench

NIBBLE_DESERIALIZER -- requirements
Module: nibble_deserializer

---
 rtl/nibble_deserializer.sv | 115 +++++++++++
 tb/tb_nibble_deserializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel receiver: shifts MSB-first bits into WIDTH-bit words
// and delivers them over a valid/ready output with a one-word stall buffer.
module nibble_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     clr,
    input  logic                     sin,
    input  logic                     sin_valid,
    output logic                     sin_ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [3:0]               word_cnt,
    output logic                     drop_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [3:0]       word_cnt_q, word_cnt_d;
    logic             drop_q, drop_d;

    logic             accept;
    logic             handshake;
    logic             complete;
    logic [WIDTH-1:0] next_word;

    always_comb begin
        sin_ready    = areset_n && (state_q == COLLECT) && !clr;
        accept       = sin_valid && sin_ready;
        handshake    = dout_valid_q && dout_ready;
        next_word    = {shift_q[WIDTH-2:0], sin};
        complete     = accept && (bit_cnt_q == LAST);

        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        drop_d       = drop_q;
        word_cnt_d   = handshake ? word_cnt_q + 4'd1 : word_cnt_q;

        // A handshake empties the output unless a new word lands below.
        if (handshake) dout_valid_d = 1'b0;

        if (clr) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = COLLECT;
            drop_d    = 1'b0;
        end else if (state_q == STALL) begin
            if (sin_valid) drop_d = 1'b1;
            if (dout_ready) begin
                dout_d       = shift_q;
                dout_valid_d = 1'b1;
                shift_d      = '0;
                state_d      = COLLECT;
            end
        end else if (complete) begin
            bit_cnt_d = '0;
            if (!dout_valid_q || dout_ready) begin
                dout_d       = next_word;
                dout_valid_d = 1'b1;
                shift_d      = '0;
            end else begin
                // Output busy: park the finished word in the shifter.
                shift_d = next_word;
                state_d = STALL;
            end
        end else if (accept) begin
            shift_d   = next_word;
            bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= COLLECT;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            word_cnt_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_cnt_q   <= word_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign bit_cnt    = bit_cnt_q;
    assign word_cnt   = word_cnt_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: directed vector table, hand sequences for
// wrap and mid-word reset, and random traffic against a word-level model.
module tb_nibble_deserializer;

    localparam int WIDTH = 4;

    logic       clk;
    logic       areset_n;
    logic       clr;
    logic       sin;
    logic       sin_valid;
    logic       sin_ready;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [1:0] bit_cnt;
    logic [3:0] word_cnt;
    logic       drop_err;

    nibble_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .clr        (clr),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .bit_cnt    (bit_cnt),
        .word_cnt   (word_cnt),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Word-level reference: partial word as an integer plus bit count,
    // an optional parked word, and the output register.
    int m_part, m_nb, m_stall_word, m_out, m_words;
    bit m_stalled, m_out_v, m_drop;

    function automatic void m_reset();
        m_part = 0; m_nb = 0; m_stall_word = 0; m_out = 0; m_words = 0;
        m_stalled = 0; m_out_v = 0; m_drop = 0;
    endfunction

    function automatic void m_step(bit v, bit s, bit r, bit c);
        bit hs, loaded;
        hs = m_out_v && r;
        loaded = 0;
        if (hs) m_words++;
        if (c) begin
            m_part = 0; m_nb = 0; m_stalled = 0; m_drop = 0;
        end else if (m_stalled) begin
            if (v) m_drop = 1;
            if (r) begin
                m_out = m_stall_word; loaded = 1; m_stalled = 0;
            end
        end else if (v) begin
            m_part = m_part * 2 + int'(s);
            m_nb++;
            if (m_nb == WIDTH) begin
                if (!m_out_v || r) begin
                    m_out = m_part; loaded = 1;
                end else begin
                    m_stalled = 1; m_stall_word = m_part;
                end
                m_part = 0; m_nb = 0;
            end
        end
        if (loaded) m_out_v = 1;
        else if (hs) m_out_v = 0;
    endfunction

    task automatic check_model();
        check("dout", dout, m_out);
        check("dout_valid", dout_valid, m_out_v);
        check("bit_cnt", bit_cnt, m_nb);
        check("word_cnt", word_cnt, m_words % 16);
        check("drop_err", drop_err, m_drop);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " dout"}, dout, 0);
        check({tag, " dout_valid"}, dout_valid, 0);
        check({tag, " bit_cnt"}, bit_cnt, 0);
        check({tag, " word_cnt"}, word_cnt, 0);
        check({tag, " drop_err"}, drop_err, 0);
        check({tag, " sin_ready"}, sin_ready, 0);
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic mstep(input bit v, input bit s, input bit r, input bit c);
        sin_valid = v; sin = s; dout_ready = r; clr = c;
        #1;
        check("sin_ready", sin_ready, !m_stalled && !c);
        m_step(v, s, r, c);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        sin_valid = 0; sin = 0; dout_ready = 0; clr = 0;
        areset_n = 0;
        #1;
        check_zero("in_reset");
        @(posedge clk);
        #1;
        check_zero("held_reset");
        areset_n = 1;
        m_reset();
        #1;
        check("ready_after_reset", sin_ready, 1);
    endtask

    typedef struct {
        bit         v, s, r, c;
        logic [3:0] dout;
        bit         dv;
        logic [1:0] bc;
        logic [3:0] wc;
        bit         drop, rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit v, bit s, bit r, bit c, int d, bit dv,
                                int bc, int wc, bit drop, bit rdy);
        vec_t t;
        t.v = v; t.s = s; t.r = r; t.c = c;
        t.dout = 4'(d); t.dv = dv; t.bc = 2'(bc); t.wc = 4'(wc);
        t.drop = drop; t.rdy = rdy;
        vecs.push_back(t);
    endfunction

    initial begin
        areset_n = 1; clr = 0; sin = 0; sin_valid = 0; dout_ready = 0;
        // v s r c | dout dv bc wc drop rdy
        add(1,1,1,0, 'h0,0,1,0,0,1);
        add(1,0,1,0, 'h0,0,2,0,0,1);
        add(1,1,1,0, 'h0,0,3,0,0,1);
        add(1,1,1,0, 'hB,1,0,0,0,1);
        add(0,0,1,0, 'hB,0,0,1,0,1);
        add(1,1,0,0, 'hB,0,1,1,0,1);
        add(1,0,0,0, 'hB,0,2,1,0,1);
        add(1,1,0,0, 'hB,0,3,1,0,1);
        add(1,0,0,0, 'hA,1,0,1,0,1);
        add(1,0,0,0, 'hA,1,1,1,0,1);
        add(1,1,0,0, 'hA,1,2,1,0,1);
        add(1,1,0,0, 'hA,1,3,1,0,1);
        add(1,0,0,0, 'hA,1,0,1,0,0);
        add(0,0,1,0, 'h6,1,0,2,0,1);
        add(0,0,1,0, 'h6,0,0,3,0,1);
        add(1,1,0,0, 'h6,0,1,3,0,1);
        add(1,0,0,0, 'h6,0,2,3,0,1);
        add(1,1,0,0, 'h6,0,3,3,0,1);
        add(1,0,0,0, 'hA,1,0,3,0,1);
        add(1,1,0,0, 'hA,1,1,3,0,1);
        add(1,1,0,0, 'hA,1,2,3,0,1);
        add(1,1,0,0, 'hA,1,3,3,0,1);
        add(1,1,0,0, 'hA,1,0,3,0,0);
        add(1,0,0,0, 'hA,1,0,3,1,0);
        add(0,0,0,1, 'hA,1,0,3,0,0);
        add(0,0,1,0, 'hA,0,0,4,0,1);
        add(1,1,1,0, 'hA,0,1,4,0,1);
        add(1,1,1,0, 'hA,0,2,4,0,1);
        add(1,1,1,1, 'hA,0,0,4,0,0);
        add(1,0,1,0, 'hA,0,1,4,0,1);
        add(1,0,1,0, 'hA,0,2,4,0,1);
        add(1,1,1,0, 'hA,0,3,4,0,1);
        add(1,1,1,0, 'h3,1,0,4,0,1);
        add(0,0,1,0, 'h3,0,0,5,0,1);
        add(1,0,0,0, 'h3,0,1,5,0,1);
        add(1,1,0,0, 'h3,0,2,5,0,1);
        add(1,0,0,0, 'h3,0,3,5,0,1);
        add(1,1,0,0, 'h5,1,0,5,0,1);
        add(0,0,1,1, 'h5,0,0,6,0,0);

        @(posedge clk);
        #1;
        do_reset();
        foreach (vecs[i]) begin
            sin_valid = vecs[i].v; sin = vecs[i].s;
            dout_ready = vecs[i].r; clr = vecs[i].c;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d dout", i), dout, vecs[i].dout);
            check($sformatf("vec%0d dout_valid", i), dout_valid, vecs[i].dv);
            check($sformatf("vec%0d bit_cnt", i), bit_cnt, vecs[i].bc);
            check($sformatf("vec%0d word_cnt", i), word_cnt, vecs[i].wc);
            check($sformatf("vec%0d drop_err", i), drop_err, vecs[i].drop);
            check($sformatf("vec%0d sin_ready", i), sin_ready, vecs[i].rdy);
        end

        // word counter wrap after 16 and 17 handshakes
        do_reset();
        for (int w = 1; w <= 17; w++) begin
            for (int b = 0; b < WIDTH; b++) mstep(1, 1'($urandom), 1, 0);
            mstep(0, 0, 1, 0);
            if (w == 16) check("wrap16 word_cnt", word_cnt, 0);
            if (w == 17) check("wrap17 word_cnt", word_cnt, 1);
        end

        // reset asserted mid-word discards the partial bits
        do_reset();
        for (int b = 0; b < 3; b++) mstep(1, 1'(b), 1, 0);
        areset_n = 0;
        #1;
        check_zero("midword_reset");
        @(posedge clk);
        #1;
        check_zero("midword_held");
        areset_n = 1;
        m_reset();
        for (int b = 0; b < WIDTH; b++) mstep(1, 1, 1, 0);
        check("after_reset dout", dout, 'hF);
        check("after_reset dout_valid", dout_valid, 1);
        mstep(0, 0, 1, 0);
        check("after_reset word_cnt", word_cnt, 1);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                mstep($urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 24) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
